// File: rtl/cond_issue_ctrl.sv
// cond_issue_ctrl: ARM condition evaluation, NZCV ownership and flag-hazard issue control.
// Optional macro COND_FLAG_FORWARD_EN bypasses a single pending flag writeback into evaluation.
module cond_issue_ctrl #(
    parameter int MAX_PENDING = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [3:0]             issue_cond,
    input  logic                   issue_sets_flags,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic                   ex_pass,
    output logic                   ex_sets_flags,
    input  logic                   wb_valid,
    input  logic [3:0]             wb_nzcv,
    input  logic                   msr_valid,
    input  logic [3:0]             msr_nzcv,
    input  logic                   flush,
    output logic [3:0]             nzcv,
    output logic [2:0]             pending,
    output logic                   err_underflow,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   state
);
    typedef enum logic {RUN = 1'b0, WAIT_FLAGS = 1'b1} state_t;
    state_t st;
    logic fwd, needs_flags, hazard, slot_free, full, accept, cond_pass, inc, dec;
    logic [3:0] f;
`ifdef COND_FLAG_FORWARD_EN
    assign fwd = pending == 3'd1 && wb_valid && !msr_valid;
`else
    assign fwd = 1'b0;
`endif
    assign f           = fwd ? wb_nzcv : nzcv;
    assign needs_flags = issue_cond[3:1] != 3'b111;
    assign hazard      = issue_valid && needs_flags && pending != 3'd0 && !fwd;
    assign slot_free   = !ex_valid || ex_ready;
    assign full        = issue_sets_flags && pending == 3'(MAX_PENDING);
    assign issue_ready = !rst && !flush && slot_free && !hazard && !full;
    assign accept      = issue_valid && issue_ready;
    assign inc         = accept && issue_sets_flags && cond_pass;
    assign dec         = wb_valid && pending != 3'd0;
    assign state       = st;
    // f = {N,Z,C,V}
    always_comb begin
        cond_pass = 1'b0;
        case (issue_cond)
            4'b0000: cond_pass = f[2];
            4'b0001: cond_pass = !f[2];
            4'b0010: cond_pass = f[1];
            4'b0011: cond_pass = !f[1];
            4'b0100: cond_pass = f[3];
            4'b0101: cond_pass = !f[3];
            4'b0110: cond_pass = f[0];
            4'b0111: cond_pass = !f[0];
            4'b1000: cond_pass = f[1] && !f[2];
            4'b1001: cond_pass = !f[1] || f[2];
            4'b1010: cond_pass = f[3] == f[0];
            4'b1011: cond_pass = f[3] != f[0];
            4'b1100: cond_pass = !f[2] && (f[3] == f[0]);
            4'b1101: cond_pass = f[2] || (f[3] != f[0]);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv          <= 4'd0;
            pending       <= 3'd0;
            ex_valid      <= 1'b0;
            ex_pass       <= 1'b0;
            ex_sets_flags <= 1'b0;
            err_underflow <= 1'b0;
            stall_count   <= '0;
            st            <= RUN;
        end else begin
            nzcv <= msr_valid ? msr_nzcv : wb_valid ? wb_nzcv : nzcv;
            if (wb_valid && pending == 3'd0) err_underflow <= 1'b1;
            if (hazard && !(&stall_count)) stall_count <= stall_count + 1'b1;
            if (flush) begin
                ex_valid      <= 1'b0;
                ex_pass       <= 1'b0;
                ex_sets_flags <= 1'b0;
                pending       <= 3'd0;
                st            <= RUN;
            end else begin
                pending <= pending + {2'b0, inc} - {2'b0, dec};
                st      <= hazard ? WAIT_FLAGS : RUN;
                if (accept) begin
                    ex_valid      <= 1'b1;
                    ex_pass       <= cond_pass;
                    ex_sets_flags <= issue_sets_flags && cond_pass;
                end else if (ex_ready) begin
                    ex_valid <= 1'b0;
                end
            end
        end
    end
endmodule
